// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared state encoding and latency constants for the multiply/divide engine
package muldiv_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int ITERATIONS    = WIDTH_DEFAULT;
    localparam int MULT_LAT      = ITERATIONS + 1;
    localparam int DIV_LAT       = ITERATIONS + 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MULT = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4,
        DZ   = 3'd5
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 Booth step or one restoring-division step (combinational)
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             div_mode,
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] q,
    input  logic             q_m1,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   next_acc,
    output logic [WIDTH-1:0] next_q,
    output logic             next_q_m1
);

    logic [WIDTH:0] m_signed;
    logic [WIDTH:0] booth_sum;
    logic [WIDTH:0] shifted_rem;
    logic [WIDTH:0] trial;

    always_comb begin
        m_signed    = {m[WIDTH-1], m};
        booth_sum   = acc;
        shifted_rem = {acc[WIDTH-1:0], q[WIDTH-1]};
        // Divisor magnitude is unsigned here, so it is zero-extended.
        trial       = shifted_rem - {1'b0, m};
        next_acc    = acc;
        next_q      = q;
        next_q_m1   = 1'b0;

        case ({q[0], q_m1})
            2'b10:   booth_sum = acc - m_signed;
            2'b01:   booth_sum = acc + m_signed;
            default: booth_sum = acc;
        endcase

        if (div_mode) begin
            if (!trial[WIDTH]) begin
                next_acc = trial;
                next_q   = {q[WIDTH-2:0], 1'b1};
            end else begin
                next_acc = shifted_rem;
                next_q   = {q[WIDTH-2:0], 1'b0};
            end
        end else begin
            next_acc  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            next_q    = {booth_sum[0], q[WIDTH-1:1]};
            next_q_m1 = q[0];
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative signed mult/div engine with its own sequencing FSM
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi_result,
    output logic [WIDTH-1:0] lo_result
);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q;
    logic             q_m1;
    logic [WIDTH-1:0] m;
    logic             neg_quot;
    logic             neg_rem;

    logic [WIDTH:0]   step_acc;
    logic [WIDTH-1:0] step_q;
    logic             step_q_m1;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic             last_step;

    assign a_neg     = op_a[WIDTH-1];
    assign b_neg     = op_b[WIDTH-1];
    assign a_abs     = a_neg ? -op_a : op_a;
    assign b_abs     = b_neg ? -op_b : op_b;
    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign divzero = (state == DZ);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_mode  (state == DIV),
        .acc       (acc),
        .q         (q),
        .q_m1      (q_m1),
        .m         (m),
        .next_acc  (step_acc),
        .next_q    (step_q),
        .next_q_m1 (step_q_m1)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (mult_start) begin
                    state_next = MULT;
                end else if (div_start) begin
                    state_next = (op_b == '0) ? DZ : DIV;
                end
            end
            MULT:    if (last_step) state_next = DONE;
            DIV:     if (last_step) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            DZ:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Results are written on the edge entering DONE so they are valid while done is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            acc       <= '0;
            q         <= '0;
            q_m1      <= 1'b0;
            m         <= '0;
            neg_quot  <= 1'b0;
            neg_rem   <= 1'b0;
            hi_result <= '0;
            lo_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mult_start) begin
                        acc  <= '0;
                        q    <= op_b;
                        q_m1 <= 1'b0;
                        m    <= op_a;
                        cnt  <= '0;
                    end else if (div_start && op_b != '0) begin
                        acc      <= '0;
                        q        <= a_abs;
                        q_m1     <= 1'b0;
                        m        <= b_abs;
                        neg_quot <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        cnt      <= '0;
                    end
                end
                MULT, DIV: begin
                    acc  <= step_acc;
                    q    <= step_q;
                    q_m1 <= step_q_m1;
                    cnt  <= cnt + 1'b1;
                    if (state == MULT && last_step) begin
                        hi_result <= step_acc[WIDTH-1:0];
                        lo_result <= step_q;
                    end
                end
                FIX: begin
                    // Truncation toward zero: remainder takes the dividend's sign.
                    lo_result <= neg_quot ? -q : q;
                    hi_result <= neg_rem ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mult_start = 1'b0;
    logic        div_start = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy, done, divzero;
    logic [31:0] hi_result, lo_result;

    int errors = 0;
    int checks = 0;

    muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .mult_start (mult_start),
        .div_start  (div_start),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .divzero    (divzero),
        .hi_result  (hi_result),
        .lo_result  (lo_result)
    );

    always #5 clk = ~clk;

    // Edge 1 is the edge that samples the start; observations are taken on the following negedge.
    task automatic run_op(input logic m_go, input logic d_go, input logic [31:0] a, input logic [31:0] b,
                          input int inj, input logic [31:0] ia, input logic [31:0] ib,
                          output int lat, output int dz_edge, output bit busy_all);
        @(negedge clk);
        mult_start = m_go;
        div_start  = d_go;
        op_a       = a;
        op_b       = b;
        lat        = -1;
        dz_edge    = -1;
        busy_all   = 1'b1;
        for (int e = 1; e <= 40 && lat < 0 && dz_edge < 0; e++) begin
            @(posedge clk);
            @(negedge clk);
            mult_start = 1'b0;
            div_start  = 1'b0;
            if (e == inj) begin
                mult_start = 1'b1;
                op_a       = ia;
                op_b       = ib;
            end
            if (busy !== 1'b1) busy_all = 1'b0;
            if (done === 1'b1) lat = e;
            if (divzero === 1'b1) dz_edge = e;
        end
        mult_start = 1'b0;
        div_start  = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy actual=%b required=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done actual=%b required=0", done); end
        checks++; if (divzero !== 1'b0) begin errors++; $display("FAIL reset_divzero actual=%b required=0", divzero); end
        checks++; if (hi_result !== 32'h0) begin errors++; $display("FAIL reset_hi actual=%h required=0", hi_result); end
        checks++; if (lo_result !== 32'h0) begin errors++; $display("FAIL reset_lo actual=%h required=0", lo_result); end
        reset = 1'b0;
    endtask

    task automatic test_mult();
        int lat, dz; bit ba;
        run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 0, 32'h0, 32'h0, lat, dz, ba);
        checks++; if (lat != MULT_LAT) begin errors++; $display("FAIL mult_latency actual=%0d required=%0d", lat, MULT_LAT); end
        checks++; if (hi_result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi actual=%h required=ffffffff", hi_result); end
        checks++; if (lo_result !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo actual=%h required=ffffffeb", lo_result); end
        checks++; if (!ba) begin errors++; $display("FAIL mult_busy_during actual=0 required=1"); end
        @(posedge clk); @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mult_after_done busy=%b done=%b required=0/0", busy, done); end
    endtask

    task automatic test_div();
        int lat, dz; bit ba;
        run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 32'h0, 32'h0, lat, dz, ba);
        checks++; if (lat != DIV_LAT) begin errors++; $display("FAIL div_latency actual=%0d required=%0d", lat, DIV_LAT); end
        checks++; if (lo_result !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_quot actual=%h required=fffffffd", lo_result); end
        checks++; if (hi_result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_rem actual=%h required=ffffffff", hi_result); end
    endtask

    task automatic test_divzero();
        int lat, dz; bit ba;
        bit saw_done;
        run_op(1'b0, 1'b1, 32'd5, 32'd0, 0, 32'h0, 32'h0, lat, dz, ba);
        checks++; if (dz != 1) begin errors++; $display("FAIL dz_edge actual=%0d required=1", dz); end
        saw_done = (lat >= 0);
        @(posedge clk); @(negedge clk);
        checks++; if (divzero !== 1'b0) begin errors++; $display("FAIL dz_pulse_width actual=%b required=0", divzero); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dz_busy_edge2 actual=%b required=0", busy); end
        repeat (3) begin
            if (done === 1'b1) saw_done = 1'b1;
            @(posedge clk); @(negedge clk);
        end
        checks++; if (saw_done) begin errors++; $display("FAIL dz_no_done actual=1 required=0"); end
        checks++; if (hi_result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_hi_hold actual=%h required=ffffffff", hi_result); end
        checks++; if (lo_result !== 32'hFFFF_FFFD) begin errors++; $display("FAIL dz_lo_hold actual=%h required=fffffffd", lo_result); end
    endtask

    task automatic test_both_starts();
        int lat, dz; bit ba;
        run_op(1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 0, 32'h0, 32'h0, lat, dz, ba);
        checks++; if (lat != MULT_LAT) begin errors++; $display("FAIL both_latency actual=%0d required=%0d", lat, MULT_LAT); end
        checks++; if (hi_result !== 32'h4000_0000) begin errors++; $display("FAIL both_hi actual=%h required=40000000", hi_result); end
        checks++; if (lo_result !== 32'h0) begin errors++; $display("FAIL both_lo actual=%h required=0", lo_result); end
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0, 32'h0, lat, dz, ba);
        checks++; if (lat != DIV_LAT) begin errors++; $display("FAIL wrap_latency actual=%0d required=%0d", lat, DIV_LAT); end
        checks++; if (lo_result !== 32'h8000_0000) begin errors++; $display("FAIL wrap_quot actual=%h required=80000000", lo_result); end
        checks++; if (hi_result !== 32'h0) begin errors++; $display("FAIL wrap_rem actual=%h required=0", hi_result); end
    endtask

    task automatic test_ignore_start();
        int lat, dz; bit ba;
        bit extra_done;
        run_op(1'b1, 1'b0, 32'd100, 32'd3, 9, 32'd5, 32'd5, lat, dz, ba);
        checks++; if (lat != MULT_LAT) begin errors++; $display("FAIL ignore_latency actual=%0d required=%0d", lat, MULT_LAT); end
        checks++; if (lo_result !== 32'd300) begin errors++; $display("FAIL ignore_lo actual=%h required=0000012c", lo_result); end
        checks++; if (hi_result !== 32'h0) begin errors++; $display("FAIL ignore_hi actual=%h required=0", hi_result); end
        extra_done = 1'b0;
        repeat (4) begin
            @(posedge clk); @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra_done = 1'b1;
        end
        checks++; if (extra_done) begin errors++; $display("FAIL ignore_not_queued actual=1 required=0"); end
    endtask

    task automatic test_reset_mid();
        int lat, dz; bit ba;
        @(negedge clk);
        div_start = 1'b1;
        op_a      = 32'd100;
        op_b      = 32'd7;
        for (int e = 1; e <= 15; e++) begin
            @(posedge clk); @(negedge clk);
            div_start = 1'b0;
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before actual=%b required=1", busy); end
        #2 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy actual=%b required=0", busy); end
        checks++; if (done !== 1'b0 || divzero !== 1'b0) begin errors++; $display("FAIL mid_pulses done=%b divzero=%b required=0/0", done, divzero); end
        checks++; if (hi_result !== 32'h0) begin errors++; $display("FAIL mid_hi actual=%h required=0", hi_result); end
        checks++; if (lo_result !== 32'h0) begin errors++; $display("FAIL mid_lo actual=%h required=0", lo_result); end
        @(negedge clk);
        reset = 1'b0;
        run_op(1'b1, 1'b0, 32'd6, 32'd7, 0, 32'h0, 32'h0, lat, dz, ba);
        checks++; if (lat != MULT_LAT) begin errors++; $display("FAIL after_reset_latency actual=%0d required=%0d", lat, MULT_LAT); end
        checks++; if (lo_result !== 32'd42) begin errors++; $display("FAIL after_reset_lo actual=%h required=0000002a", lo_result); end
        checks++; if (hi_result !== 32'h0) begin errors++; $display("FAIL after_reset_hi actual=%h required=0", hi_result); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_divzero();
        test_both_starts();
        test_ignore_start();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
